// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/subtract opcode encoding and the operand
// conditioning rules used at the entry of the add/subtract pipeline.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_ADDC = 2'd2,
        ALU_SUBB = 2'd3
    } alu_addsub_op_t;

    // Subtracting forms use the one's complement of b.
    function automatic logic op_inverts_b(alu_addsub_op_t op);
        return (op == ALU_SUB) || (op == ALU_SUBB);
    endfunction

    // Carry into bit 0: fixed for ADD/SUB, caller-supplied for ADDC/SUBB.
    function automatic logic op_carry_in(alu_addsub_op_t op, logic cin);
        logic c;
        case (op)
            ALU_ADD: c = 1'b0;
            ALU_SUB: c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe. The master side produces
// operands and consumes results; the slave side is the arithmetic unit.
interface addsub_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic               in_valid;
    logic               in_ready;
    alu_addsub_op_t     in_op;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_cin;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_cout;
    logic               out_ovf;
    logic               out_zero;
    logic               out_neg;

    modport master (
        output in_valid, in_op, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );

endinterface

// File: rtl/addsub_seg.sv
// Combinational SEG-bit adder slice. Besides the carry out it exposes the
// carry into its own MSB so the top slice can derive signed overflow.
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    generate
        if (SEG == 1) begin : g_bit
            assign c_msb = cin;
            assign sum   = a ^ b ^ cin;
        end else begin : g_wide
            // Add everything below the MSB first; its top bit is the MSB carry-in.
            logic [SEG-1:0] low;
            assign low   = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]} + {{(SEG-1){1'b0}}, cin};
            assign c_msb = low[SEG-1];
            assign sum   = {a[SEG-1] ^ b[SEG-1] ^ c_msb, low[SEG-2:0]};
        end
    endgenerate

    assign cout = (a[SEG-1] & b[SEG-1]) | (c_msb & (a[SEG-1] ^ b[SEG-1]));

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit. One SEG-bit slice is resolved per stage with
// the carry registered between stages. Unresolved upper operand bits travel
// down a shrinking triangle of registers, the resolved sum grows alongside.
// The whole pipe shifts together whenever the output side can move.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave bus
);

    localparam int STAGES = WIDTH / SEG;

    logic             advance;
    logic             last_valid;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff   = op_inverts_b(bus.in_op) ? ~bus.in_b : bus.in_b;
    assign c0      = op_carry_in(bus.in_op, bus.in_cin);
    assign advance = !last_valid || bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int IN_W  = WIDTH - gi * SEG;   // operand bits still unresolved
            localparam int SUM_W = (gi + 1) * SEG;     // sum bits resolved after this stage

            logic [IN_W-1:0]  a_src;
            logic [IN_W-1:0]  b_src;
            logic             cin_src;
            logic             valid_src;
            logic             zero_src;
            logic [SUM_W-1:0] sum_next;
            logic [SEG-1:0]   seg_sum;
            logic             seg_cout;
            logic             seg_cmsb;

            logic             valid_reg;
            logic             carry_reg;
            logic             zero_reg;
            logic [SUM_W-1:0] sum_reg;

            if (gi == 0) begin : g_entry
                assign a_src     = bus.in_a;
                assign b_src     = b_eff;
                assign cin_src   = c0;
                assign valid_src = bus.in_valid;
                assign zero_src  = 1'b1;
                assign sum_next  = seg_sum;
            end else begin : g_chain
                assign a_src     = g_stage[gi-1].g_rem.a_rem_reg;
                assign b_src     = g_stage[gi-1].g_rem.b_rem_reg;
                assign cin_src   = g_stage[gi-1].carry_reg;
                assign valid_src = g_stage[gi-1].valid_reg;
                assign zero_src  = g_stage[gi-1].zero_reg;
                assign sum_next  = {seg_sum, g_stage[gi-1].sum_reg};
            end

            addsub_seg #(.SEG(SEG)) u_seg (
                .a     (a_src[SEG-1:0]),
                .b     (b_src[SEG-1:0]),
                .cin   (cin_src),
                .sum   (seg_sum),
                .cout  (seg_cout),
                .c_msb (seg_cmsb)
            );

            // Stage control and resolved result; bubbles travel as valid = 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    zero_reg  <= 1'b0;
                    sum_reg   <= '0;
                end else if (advance) begin
                    valid_reg <= valid_src;
                    carry_reg <= seg_cout;
                    zero_reg  <= zero_src && (seg_sum == '0);
                    sum_reg   <= sum_next;
                end
            end

            if (IN_W > SEG) begin : g_rem
                logic [IN_W-SEG-1:0] a_rem_reg;
                logic [IN_W-SEG-1:0] b_rem_reg;

                // Carry the not-yet-added operand segments to the next stage.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_rem_reg <= '0;
                        b_rem_reg <= '0;
                    end else if (advance) begin
                        a_rem_reg <= a_src[IN_W-1:SEG];
                        b_rem_reg <= b_src[IN_W-1:SEG];
                    end
                end
            end

            if (gi == STAGES - 1) begin : g_last
                logic ovf_reg;

                // Signed overflow: carry into the MSB differs from carry out of it.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg <= 1'b0;
                    end else if (advance) begin
                        ovf_reg <= seg_cmsb ^ seg_cout;
                    end
                end
            end else begin : g_mid
                // Only the top slice's MSB carry matters.
                logic unused_cmsb;
                assign unused_cmsb = seg_cmsb;
            end
        end
    endgenerate

    assign last_valid    = g_stage[STAGES-1].valid_reg;
    assign bus.in_ready  = advance;
    assign bus.out_valid = last_valid;
    // Results are masked to zero whenever no beat is presented.
    assign bus.out_sum   = last_valid ? g_stage[STAGES-1].sum_reg : '0;
    assign bus.out_cout  = last_valid && g_stage[STAGES-1].carry_reg;
    assign bus.out_ovf   = last_valid && g_stage[STAGES-1].g_last.ovf_reg;
    assign bus.out_zero  = last_valid && g_stage[STAGES-1].zero_reg;
    assign bus.out_neg   = last_valid && g_stage[STAGES-1].sum_reg[WIDTH-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed and random beats, stall patterns and a
// mid-flight reset, checked every cycle against a whole-word arithmetic model.
module tb_addsub_pipe;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int STAGES = WIDTH / SEG;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
        int   stalls;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    addsub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   stall_cnt  = 0;
    int   ready_mode = 0;   // 0: always ready, 1: 1-in-3 stall, 2: never ready
    ent_t exp_q[$];
    ent_t ent_v;
    res_t cur;
    res_t prev_out;
    bit   hold_prev  = 1'b0;

    // Reference: plain full-width arithmetic straight from the op definitions.
    function automatic res_t model(alu_addsub_op_t op, logic [WIDTH-1:0] a,
                                   logic [WIDTH-1:0] b, logic cin);
        logic [WIDTH-1:0] bb;
        logic             c;
        logic [WIDTH:0]   full;
        res_t             r;
        bb     = (op == ALU_SUB || op == ALU_SUBB) ? ~b : b;
        c      = (op == ALU_ADD) ? 1'b0 : (op == ALU_SUB) ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        r.zero = (r.sum == '0);
        r.neg  = r.sum[WIDTH-1];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle monitor: handshake rule, hold stability, ordering, values, latency.
    always @(negedge clk) begin
        cyc++;
        cur = {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg};
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
            check("reset_out_valid", 64'(bus.out_valid), 64'(0));
            check("reset_out_data", 64'(cur), 64'(0));
        end else begin
            check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (hold_prev)
                check("hold_stable", 64'({bus.out_valid, cur}), 64'({1'b1, prev_out}));
            if (!bus.out_valid)
                check("idle_out_zero", 64'(cur), 64'(0));
            if (bus.out_valid && !bus.out_ready)
                stall_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    ent_v = exp_q.pop_front();
                    check("result", 64'(cur), 64'(ent_v.r));
                    check("latency", 64'(cyc - ent_v.cyc), 64'(STAGES + stall_cnt - ent_v.stalls));
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back('{r: model(bus.in_op, bus.in_a, bus.in_b, bus.in_cin),
                                  cyc: cyc, stalls: stall_cnt});
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_out  = cur;
        end
    end

    // Consumer back-pressure generator.
    initial begin : ready_gen
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 3) != 0;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input alu_addsub_op_t op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin);
        bit acc;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready && rst_n;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : drive
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        bus.in_valid = 1'b0;
        bus.in_op    = ALU_ADD;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));

        // Hand-derived values pin the reference model itself.
        check("pin_add_ovf",  64'(model(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0)), 64'({32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1}));
        check("pin_sub_neg",  64'(model(ALU_SUB,  32'd5, 32'd7, 1'b0)),                64'({32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1}));
        check("pin_sub_pos",  64'(model(ALU_SUB,  32'd7, 32'd5, 1'b0)),                64'({32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0}));
        check("pin_sub_eq",   64'(model(ALU_SUB,  32'h1234ABCD, 32'h1234ABCD, 1'b0)),  64'({32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}));
        check("pin_addc",     64'(model(ALU_ADDC, 32'hFFFFFFFF, 32'h0, 1'b1)),         64'({32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}));
        check("pin_subb_ovf", 64'(model(ALU_SUBB, 32'h80000000, 32'h1, 1'b1)),         64'({32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0}));

        // Directed vectors, always ready, including cross-segment carry ripples.
        send(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0);
        send(ALU_SUB,  32'd5,        32'd7,        1'b0);
        send(ALU_SUB,  32'd7,        32'd5,        1'b0);
        send(ALU_SUB,  32'h1234ABCD, 32'h1234ABCD, 1'b0);
        send(ALU_ADDC, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        send(ALU_SUBB, 32'h80000000, 32'h00000001, 1'b1);
        send(ALU_ADD,  32'h00FFFFFF, 32'h00000001, 1'b0);
        send(ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 1'b0);
        send(ALU_SUB,  32'h00000000, 32'h00000001, 1'b0);
        send(ALU_ADDC, 32'h0000FF00, 32'h00000100, 1'b0);
        send(ALU_SUBB, 32'h00000010, 32'h00000010, 1'b0);
        drain();

        // Back-to-back random beats under a 1-in-3 output stall pattern.
        ready_mode = 1;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom();
            rb = $urandom();
            send(alu_addsub_op_t'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        drain();

        // Long stall with a result held at the output.
        ready_mode = 2;
        send(ALU_SUB, 32'h00000003, 32'h00000009, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("stall_out_valid", 64'(bus.out_valid), 64'(1));
        check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        ready_mode = 0;
        drain();

        // Reset with one beat at the output and three in flight.
        send(ALU_ADD, 32'h11111111, 32'h22222222, 1'b0);
        send(ALU_ADD, 32'h33333333, 32'h44444444, 1'b0);
        send(ALU_SUB, 32'h55555555, 32'h66666666, 1'b0);
        send(ALU_ADDC, 32'h77777777, 32'h88888888, 1'b1);
        check("pre_reset_out_valid", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("reset_immediate", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(ALU_SUB, 32'hDEADBEEF, 32'h0000BEEF, 1'b0);
        drain();
        repeat (10) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
